// File: rtl/multi_digit_ssd_scanner.sv
// Time-multiplexed seven-segment scanner: NUM_DIGITS hex digits on a shared
// segment bus, with strobed shadow load, per-digit decimal points, optional
// leading-zero blanking and 16-level PWM brightness per digit slot.
module multi_digit_ssd_scanner #(
   parameter int unsigned NUM_DIGITS     = 8,
   parameter int unsigned REFRESH_DIV    = 16384,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [4*NUM_DIGITS-1:0]   din,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz,
   input  logic                      din_valid,
   input  logic [3:0]                brightness,
   output logic [6:0]                dout,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     sel
);

   localparam int unsigned PRE_CNT = REFRESH_DIV / 16;
   localparam int unsigned PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
   localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

   logic [PRE_W-1:0]        r_pre;
   logic [3:0]              r_phase;
   logic [DIG_W-1:0]        r_digit;
   logic [3:0]              r_bright;
   logic [4*NUM_DIGITS-1:0] r_din_sh;
   logic [NUM_DIGITS-1:0]   r_dp_sh;
   logic                    r_blz_sh;
   logic [6:0]              r_dout;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_sel;

   logic                    w_pre_wrap;
   logic                    w_phase_wrap;
   logic                    w_slot_start;
   logic [3:0]              w_bright;
   logic                    w_en;
   logic [3:0]              w_nib;
   logic                    w_dp_sel;
   logic                    w_blank;
   logic [6:0]              w_seg_hi;
   logic [NUM_DIGITS-1:0]   w_sel_hi;

   assign w_pre_wrap   = (r_pre == PRE_W'(PRE_CNT - 1));
   assign w_phase_wrap = w_pre_wrap && (r_phase == 4'hF);
   assign w_slot_start = (r_pre == '0) && (r_phase == 4'h0);
   // The first cycle of a slot already uses the freshly sampled brightness
   assign w_bright     = w_slot_start ? brightness : r_bright;
   assign w_en         = (r_phase < w_bright);

   // Free-running prescaler -> phase -> digit index chain and brightness latch
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pre    <= '0;
         r_phase  <= 4'h0;
         r_digit  <= '0;
         r_bright <= 4'h0;
      end else begin
         r_pre <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
         if (w_pre_wrap) begin
            r_phase <= r_phase + 4'd1;
         end
         if (w_phase_wrap) begin
            r_digit <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);
         end
         if (w_slot_start) begin
            r_bright <= brightness;
         end
      end
   end

   // Shadow registers captured only on the load strobe, so the scan never tears
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_din_sh <= '0;
         r_dp_sh  <= '0;
         r_blz_sh <= 1'b0;
      end else if (din_valid) begin
         r_din_sh <= din;
         r_dp_sh  <= dp_in;
         r_blz_sh <= blank_lz;
      end
   end

   // Select current digit's nibble/dp, leading-zero blank flag and one-hot enable
   always_comb begin : p_digit_sel
      logic v_zero_above;
      w_nib        = 4'h0;
      w_dp_sel     = 1'b0;
      w_blank      = 1'b0;
      w_sel_hi     = '0;
      v_zero_above = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         v_zero_above = v_zero_above && (r_din_sh[4*i +: 4] == 4'h0);
         if (r_digit == DIG_W'(i)) begin
            w_nib       = r_din_sh[4*i +: 4];
            w_dp_sel    = r_dp_sh[i];
            w_blank     = r_blz_sh && v_zero_above && (i != 0);
            w_sel_hi[i] = w_en;
         end
      end
   end

   // Hex to seven-segment decode, active-high {g,f,e,d,c,b,a}
   always_comb begin
      w_seg_hi = 7'h00;
      case (w_nib)
         4'h0: w_seg_hi = 7'h3F;
         4'h1: w_seg_hi = 7'h06;
         4'h2: w_seg_hi = 7'h5B;
         4'h3: w_seg_hi = 7'h4F;
         4'h4: w_seg_hi = 7'h66;
         4'h5: w_seg_hi = 7'h6D;
         4'h6: w_seg_hi = 7'h7D;
         4'h7: w_seg_hi = 7'h07;
         4'h8: w_seg_hi = 7'h7F;
         4'h9: w_seg_hi = 7'h6F;
         4'hA: w_seg_hi = 7'h77;
         4'hB: w_seg_hi = 7'h7C;
         4'hC: w_seg_hi = 7'h39;
         4'hD: w_seg_hi = 7'h5E;
         4'hE: w_seg_hi = 7'h79;
         default: w_seg_hi = 7'h71;
      endcase
   end

   // Registered pin drive; segments and dp forced off whenever the digit is dark
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sel  <= SEL_OFF;
         r_dout <= SEG_OFF;
         r_dp   <= DP_OFF;
      end else begin
         r_sel  <= SEL_ACTIVE_LOW ? ~w_sel_hi : w_sel_hi;
         r_dout <= (w_en && !w_blank) ? (SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi) : SEG_OFF;
         r_dp   <= (w_en && w_dp_sel) ? ~DP_OFF : DP_OFF;
      end
   end

   assign dout = r_dout;
   assign dp   = r_dp;
   assign sel  = r_sel;

endmodule

// File: tb/tb_multi_digit_ssd_scanner.sv
// Directed bench for multi_digit_ssd_scanner: 4-digit main instance plus
// 1-digit and 16-digit instances for width/wrap coverage.
module tb_multi_digit_ssd_scanner;

   logic        clk;
   logic        rstn;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        din_valid;
   logic [3:0]  brightness;
   logic [6:0]  dout;
   logic        dp;
   logic [3:0]  sel;

   logic [3:0]  din1;
   logic [0:0]  dp_in1;
   logic        din_valid1;
   logic [6:0]  dout1;
   logic        dp1;
   logic [0:0]  sel1;

   logic [63:0] din16;
   logic [15:0] dp_in16;
   logic        din_valid16;
   logic [6:0]  dout16;
   logic        dp16;
   logic [15:0] sel16;

   logic [3:0]  bright_w;
   logic        blz_w;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   multi_digit_ssd_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(32),
                             .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut (
      .clk(clk), .rstn(rstn), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
      .din_valid(din_valid), .brightness(brightness), .dout(dout), .dp(dp), .sel(sel));

   multi_digit_ssd_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(16),
                             .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut1 (
      .clk(clk), .rstn(rstn), .din(din1), .dp_in(dp_in1), .blank_lz(blz_w),
      .din_valid(din_valid1), .brightness(bright_w), .dout(dout1), .dp(dp1), .sel(sel1));

   multi_digit_ssd_scanner #(.NUM_DIGITS(16), .REFRESH_DIV(16),
                             .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut16 (
      .clk(clk), .rstn(rstn), .din(din16), .dp_in(dp_in16), .blank_lz(blz_w),
      .din_valid(din_valid16), .brightness(bright_w), .dout(dout16), .dp(dp16), .sel(sel16));

   // Wait (sampling on negedges) until the main sel equals want, bounded
   task automatic wait_sel(input logic [3:0] want, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sel === want) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Load the main instance shadows with a one-cycle strobe
   task automatic load(input logic [15:0] d, input logic [3:0] p, input logic b);
      din       = d;
      dp_in     = p;
      blank_lz  = b;
      din_valid = 1'b1;
      @(posedge clk);
      #1 din_valid = 1'b0;
      @(negedge clk);
   endtask

   // Align to the first enabled cycle of digit 0
   task automatic sync_digit0(input string tag);
      bit ok0, ok1;
      wait_sel(4'b0111, 400, ok0);
      wait_sel(4'b1110, 400, ok1);
      checks++;
      if (!(ok0 && ok1)) begin
         errors++;
         $display("FAIL %s sync: timed out waiting for digit 0, sel=%b", tag, sel);
      end
   endtask

   task automatic test_reset;
      brightness = 4'd15;
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (sel !== 4'b1111 || dout !== 7'h7F || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_init: sel=%b dout=%h dp=%b want 1111/7f/1", sel, dout, dp);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (50) @(negedge clk);
      checks++;
      if (sel !== 4'b1101 || dout !== 7'h40) begin
         errors++;
         $display("FAIL reset_prescan: sel=%b dout=%h want 1101/40", sel, dout);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (sel !== 4'b1111 || dout !== 7'h7F || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_midscan: sel=%b dout=%h dp=%b want 1111/7f/1", sel, dout, dp);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (sel !== 4'b1110 || dout !== 7'h40 || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_restart: sel=%b dout=%h dp=%b want 1110/40/1", sel, dout, dp);
      end
      repeat (32) @(negedge clk);
      checks++;
      if (sel !== 4'b1101) begin
         errors++;
         $display("FAIL reset_digit1: sel=%b want 1101", sel);
      end
   endtask

   task automatic test_scan_decode;
      logic [3:0] esel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] eseg [4] = '{7'h0E, 7'h24, 7'h08, 7'h79};
      logic       edp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      int cnt;
      brightness = 4'd15;
      load(16'h1A2F, 4'b0100, 1'b0);
      sync_digit0("scan");
      for (int d = 0; d < 4; d++) begin
         cnt = 0;
         for (int s = 0; s < 32; s++) begin
            if (sel === esel[d]) cnt++;
            if (s == 0) begin
               checks++;
               if (sel !== esel[d] || dout !== eseg[d] || dp !== edp[d]) begin
                  errors++;
                  $display("FAIL scan_digit%0d: sel=%b dout=%h dp=%b want %b/%h/%b",
                           d, sel, dout, dp, esel[d], eseg[d], edp[d]);
               end
            end
            if (s == 31) begin
               checks++;
               if (sel !== 4'b1111 || dout !== 7'h7F || dp !== 1'b1) begin
                  errors++;
                  $display("FAIL scan_dark%0d: sel=%b dout=%h dp=%b want 1111/7f/1",
                           d, sel, dout, dp);
               end
            end
            @(negedge clk);
         end
         checks++;
         if (cnt != 30) begin
            errors++;
            $display("FAIL scan_duty%0d: enabled %0d cycles want 30", d, cnt);
         end
      end
      checks++;
      if (sel !== 4'b1110 || dout !== 7'h0E) begin
         errors++;
         $display("FAIL scan_repeat: sel=%b dout=%h want 1110/0e", sel, dout);
      end
   endtask

   task automatic test_lz_blank;
      logic [3:0]  esel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [15:0] vals [2] = '{16'h0050, 16'h0000};
      logic [6:0]  eseg [2][4] = '{'{7'h40, 7'h12, 7'h7F, 7'h7F},
                                   '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
      for (int p = 0; p < 2; p++) begin
         load(vals[p], 4'b0000, 1'b1);
         sync_digit0("lz");
         for (int d = 0; d < 4; d++) begin
            checks++;
            if (sel !== esel[d] || dout !== eseg[p][d] || dp !== 1'b1) begin
               errors++;
               $display("FAIL lz_p%0d_digit%0d: sel=%b dout=%h dp=%b want %b/%h/1",
                        p, d, sel, dout, dp, esel[d], eseg[p][d]);
            end
            repeat (32) @(negedge clk);
         end
      end
   endtask

   task automatic test_load_handshake;
      din = 16'h1234;
      sync_digit0("hs");
      checks++;
      if (dout !== 7'h40) begin
         errors++;
         $display("FAIL hs_nostrobe0: dout=%h want 40", dout);
      end
      repeat (32) @(negedge clk);
      checks++;
      if (sel !== 4'b1101 || dout !== 7'h7F) begin
         errors++;
         $display("FAIL hs_nostrobe1: sel=%b dout=%h want 1101/7f", sel, dout);
      end
      din_valid = 1'b1;
      @(posedge clk);
      #1 din_valid = 1'b0;
      checks++;
      if (sel !== 4'b1101 || dout !== 7'h7F) begin
         errors++;
         $display("FAIL hs_capture_edge: sel=%b dout=%h want 1101/7f", sel, dout);
      end
      @(negedge clk);
      checks++;
      if (sel !== 4'b1101 || dout !== 7'h7F) begin
         errors++;
         $display("FAIL hs_pre_update: sel=%b dout=%h want 1101/7f", sel, dout);
      end
      @(negedge clk);
      checks++;
      if (sel !== 4'b1101 || dout !== 7'h30) begin
         errors++;
         $display("FAIL hs_update: sel=%b dout=%h want 1101/30", sel, dout);
      end
   endtask

   task automatic test_brightness;
      int cnt;
      brightness = 4'd4;
      sync_digit0("br4");
      cnt = 0;
      for (int s = 0; s < 32; s++) begin
         if (sel === 4'b1110) cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 8 || sel !== 4'b1101) begin
         errors++;
         $display("FAIL br4_duty: enabled %0d want 8, next sel=%b want 1101", cnt, sel);
      end
      brightness = 4'd0;
      repeat (40) @(negedge clk);
      cnt = 0;
      for (int s = 0; s < 128; s++) begin
         if (sel !== 4'b1111 || dout !== 7'h7F) cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 0) begin
         errors++;
         $display("FAIL br0_dark: %0d lit samples want 0", cnt);
      end
      brightness = 4'd4;
      sync_digit0("brmid");
      cnt = 0;
      for (int s = 0; s < 32; s++) begin
         if (sel === 4'b1110) cnt++;
         if (s == 3) brightness = 4'd15;
         @(negedge clk);
      end
      checks++;
      if (cnt != 8) begin
         errors++;
         $display("FAIL br_midslot: enabled %0d want 8", cnt);
      end
      cnt = 0;
      for (int s = 0; s < 32; s++) begin
         if (sel === 4'b1101) cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 30) begin
         errors++;
         $display("FAIL br_nextslot: enabled %0d want 30", cnt);
      end
   endtask

   task automatic test_widths;
      int  cnt;
      int  bad;
      bit  ok;
      din1        = 4'h8;
      dp_in1      = 1'b1;
      din16       = 64'hFEDC_BA98_7654_3210;
      dp_in16     = 16'h0000;
      din_valid1  = 1'b1;
      din_valid16 = 1'b1;
      @(posedge clk);
      #1;
      din_valid1  = 1'b0;
      din_valid16 = 1'b0;
      @(negedge clk);
      // single digit: align on the dark phase, then the slot start
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (sel1 === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      for (int i = 0; i < 40 && ok; i++) begin
         if (sel1 === 1'b0) break;
         @(negedge clk);
      end
      checks++;
      if (!ok || sel1 !== 1'b0 || dout1 !== 7'h00 || dp1 !== 1'b0) begin
         errors++;
         $display("FAIL w1_digit: sel=%b dout=%h dp=%b want 0/00/0", sel1, dout1, dp1);
      end
      cnt = 0;
      for (int s = 0; s < 16; s++) begin
         if (sel1 === 1'b0) cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 15) begin
         errors++;
         $display("FAIL w1_duty: enabled %0d want 15", cnt);
      end
      // sixteen digits: last digit then wrap to digit 0
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (sel16 === ~16'h8000) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok || dout16 !== 7'h0E || dp16 !== 1'b1) begin
         errors++;
         $display("FAIL w16_digit15: sel=%h dout=%h dp=%b want 7fff/0e/1", sel16, dout16, dp16);
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sel16 === ~16'h0001) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok || dout16 !== 7'h40) begin
         errors++;
         $display("FAIL w16_wrap: sel=%h dout=%h want fffe/40", sel16, dout16);
      end
      bad = 0;
      for (int s = 0; s < 300; s++) begin
         if ($isunknown({dout, dp, sel, dout1, dp1, sel1, dout16, dp16, sel16})) bad++;
         if ($countones(~sel16) > 1 || $countones(~sel) > 1) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL widths_sweep: %0d bad samples (X or multi-enable) want 0", bad);
      end
   endtask

   initial begin
      rstn        = 1'b1;
      din         = '0;
      dp_in       = '0;
      blank_lz    = 1'b0;
      din_valid   = 1'b0;
      brightness  = 4'd15;
      din1        = '0;
      dp_in1      = '0;
      din_valid1  = 1'b0;
      din16       = '0;
      dp_in16     = '0;
      din_valid16 = 1'b0;
      bright_w    = 4'd15;
      blz_w       = 1'b0;
      test_reset();
      test_scan_decode();
      test_lz_blank();
      test_load_handshake();
      test_brightness();
      test_widths();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_digit_ssd_scanner.md
Name: multi_digit_ssd_scanner

Overview:
Parametrised, time-multiplexed seven-segment display driver, the next generation of the fixed 8-digit SSD driver. It scans NUM_DIGITS hex digits on a shared segment bus and adds:
- a tear-free load handshake
- per-digit decimal points
- optional leading-zero blanking
- 16-level PWM brightness
It sits between the core's debug/MMIO register and the board's display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16).
REFRESH_DIV, 16384, clk cycles per digit slot; must be a multiple of 16 and >= 16.
SEG_ACTIVE_LOW, 1, 1 = dout/dp are driven low to light a segment.
SEL_ACTIVE_LOW, 1, 1 = sel is driven low to enable a digit.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
din  input  4*NUM_DIGITS  hex nibbles; digit i = din[4i+3:4i]; digit 0 is rightmost
dp_in  input  NUM_DIGITS  decimal point per digit
blank_lz  input  1  leading-zero blanking enable
din_valid  input  1  single-cycle load strobe for din/dp_in/blank_lz
brightness  input  4  PWM duty in sixteenths (0 = dark, 15 = 15/16)
dout  output  7  segments {g,f,e,d,c,b,a}; bit0 = a
dp  output  1  decimal-point segment
sel  output  NUM_DIGITS  digit enables; one-hot (or none) in active sense

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low; assertion takes effect immediately, including mid-scan.
- Reset values:
  - shadow registers = 0; prescaler, phase and digit index = 0
  - sel = all digits disabled
  - dout and dp = all segments off
  - brightness latch = 0
  - Polarity follows SEG_ACTIVE_LOW and SEL_ACTIVE_LOW: off/disabled is 1 when the parameter is 1.
- Load: on a clk edge with din_valid=1, the shadow registers capture din, dp_in and blank_lz. With din_valid=0 the shadows hold.
  - Changes on din have no effect without the strobe.
  - The new data appears on the outputs at the next output register update, i.e. exactly 1 cycle after the capture edge.
- Timing chain, all counters free-running:
  - prescaler counts 0..REFRESH_DIV/16-1.
  - phase (0..15) increments when the prescaler wraps.
  - digit index increments when phase wraps 15->0 at a prescaler wrap; it wraps from NUM_DIGITS-1 to 0.
- Brightness latch: samples brightness when phase=0 and prescaler=0, i.e. at the start of each slot. Mid-slot changes take effect from the next slot.
- Enable condition: the current digit is enabled when phase < latched brightness.
  - brightness=0 keeps sel all-disabled permanently.
- Segment decode, active-high form (inverted when SEG_ACTIVE_LOW=1):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Leading-zero blanking: digit i>0 is blanked when shadow blank_lz=1 and all shadow nibbles i..NUM_DIGITS-1 are 0.
  - A blanked digit has segments off, but its dp is still honoured.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Outputs are registered. sel, dout and dp update together, 1 cycle after the counter/shadow state they reflect.
- While a digit is disabled, dout and dp are also driven off, so no ghosting.
- No two digits are ever enabled in the same cycle.

Test Plan:
1. Reset. Bench parameters NUM_DIGITS=4, REFRESH_DIV=32, active-low. Assert rstn=0 mid-scan.
   -> sel=4'b1111, dout=7'h7F and dp=1 within the same cycle. Counters restart at digit 0 after release.
2. Scan order and decode. Load din=16'h1A2F, dp_in=4'b0100, brightness=15.
   -> Digits appear in order 0,1,2,3: digit0 sel=1110 dout=~71, digit1 dout=~5B, digit2 dout=~77 dp=0, digit3 dout=~06.
   -> Each digit is enabled for 30 of 32 cycles; the sequence repeats every 128 cycles.
3. Leading-zero blanking. Load din=16'h0050, blank_lz=1.
   -> Digits 3 and 2 show dout=7'h7F (blank), digit1 shows ~6D, digit0 shows ~3F.
   -> Load din=0: only digit0 is lit, showing ~3F.
4. Load handshake. Change din without din_valid.
   -> Display unchanged.
   -> Pulse din_valid while digit 1 is active: dout changes exactly 1 cycle after the capture edge, with no glitch in sel.
5. Brightness. Set brightness=4.
   -> Each digit is enabled for 8 of 32 cycles (phases 0..3).
   -> brightness=0: sel stays 1111 indefinitely.
   -> Change brightness mid-slot: the new duty applies from the next slot boundary only.
6. Widths. Parameters NUM_DIGITS=1, then 16.
   -> sel has the correct width; one-hot rotation wraps from 15 to 0; no X on any output.
